// File: rtl/crc_pkg.sv
// Shared definitions for the 3-parallel CRC front end.
//   SYM_W       : symbol width (bits presented to the CRC core per beat)
//   state_e     : feeder FSM encoding
//   data_beats  : message beats for a given message width
//   pad_beats   : augmentation beats for a given generator degree
package crc_pkg;
    localparam int SYM_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } state_e;

    function automatic int data_beats(input int msg_w);
        return msg_w / SYM_W;
    endfunction

    function automatic int pad_beats(input int crc_w);
        return crc_w / SYM_W;
    endfunction
endpackage

// File: rtl/crc3_frame_feeder_if.sv
// Handshake bundle between message source, feeder and CRC core.
//   msg_in/msg_valid/msg_ready : whole-message request channel
//   sym_out/sym_valid/sym_ready: 3-bit symbol channel (bit 2 earliest)
//   sym_first/sym_last         : frame strobes travelling with sym_out
// slave  : the feeder side; master : the driving/consuming environment.
interface crc3_frame_feeder_if #(
    parameter int MSG_W = 9
);
    logic [MSG_W-1:0] msg_in;
    logic             msg_valid;
    logic             msg_ready;
    logic [2:0]       sym_out;
    logic             sym_valid;
    logic             sym_ready;
    logic             sym_first;
    logic             sym_last;

    modport slave (
        input  msg_in, msg_valid, sym_ready,
        output msg_ready, sym_out, sym_valid, sym_first, sym_last
    );

    modport master (
        output msg_in, msg_valid, sym_ready,
        input  msg_ready, sym_out, sym_valid, sym_first, sym_last
    );
endinterface

// File: rtl/crc_sym_shifter.sv
// MSG_W-bit load / shift-left-by-SYM_W register. Zeros shift in from the
// bottom, so once the message is drained the top symbol reads as the
// augmentation pad without extra muxing.
//   clk, reset : clock, async active-low reset
//   i_load     : capture i_data (has priority over i_shift)
//   i_shift    : advance one symbol
//   o_word     : current register contents
module crc_sym_shifter
    import crc_pkg::*;
#(
    parameter int MSG_W = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [MSG_W-1:0] i_data,
    output logic [MSG_W-1:0] o_word
);
    logic [MSG_W-1:0] r_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_word <= '0;
        else if (i_load)
            r_word <= i_data;
        else if (i_shift)
            r_word <= r_word << SYM_W;
    end

    assign o_word = r_word;
endmodule

// File: rtl/crc3_frame_feeder.sv
// Slices one message word MSB-first into 3-bit symbols, appends CRC_W
// zero bits as pad beats, and frames the stream with first/last strobes.
//   clk, reset  : clock, async active-low reset
//   bus         : message and symbol handshakes (slave modport)
//   busy        : frame in progress
//   frames_done : completed-frame counter, wraps
module crc3_frame_feeder
    import crc_pkg::*;
#(
    parameter int MSG_W = 9,
    parameter int CRC_W = 3,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    crc3_frame_feeder_if.slave   bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     frames_done
);
    localparam int DATA_BEATS = data_beats(MSG_W);
    localparam int PAD_BEATS  = pad_beats(CRC_W);
    localparam int BEAT_W     = $clog2(DATA_BEATS + PAD_BEATS) + 1;

    if ((MSG_W % SYM_W) != 0 || MSG_W < SYM_W) begin : g_bad_msg_w
        $error("MSG_W must be a non-zero multiple of SYM_W");
    end
    if ((CRC_W % SYM_W) != 0 || CRC_W < SYM_W) begin : g_bad_crc_w
        $error("CRC_W must be a non-zero multiple of SYM_W");
    end

    state_e              r_state;
    logic [BEAT_W-1:0]   r_beat;
    logic [CNT_W-1:0]    r_frames;
    logic                r_sym_valid;
    logic                r_first;
    logic                r_last;
    logic                r_busy;
    logic                w_accept;
    logic                w_adv;
    logic [MSG_W-1:0]    w_word;

    // msg_ready is held low while reset is asserted so nothing is offered
    // to upstream before the block is live.
    assign bus.msg_ready = (r_state == IDLE) && reset;
    assign w_accept      = bus.msg_valid && (r_state == IDLE);
    assign w_adv         = r_sym_valid && bus.sym_ready;

    crc_sym_shifter #(.MSG_W(MSG_W)) u_shift (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_accept),
        .i_shift (w_adv),
        .i_data  (bus.msg_in),
        .o_word  (w_word)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_frames    <= '0;
            r_sym_valid <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state     <= DATA;
                        r_beat      <= '0;
                        r_sym_valid <= 1'b1;
                        r_first     <= 1'b1;
                        r_last      <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                DATA: begin
                    if (w_adv) begin
                        r_first <= 1'b0;
                        if (r_beat == BEAT_W'(DATA_BEATS - 1)) begin
                            r_state <= PAD;
                            r_beat  <= '0;
                            r_last  <= (PAD_BEATS == 1);
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                PAD: begin
                    if (w_adv) begin
                        if (r_beat == BEAT_W'(PAD_BEATS - 1)) begin
                            r_state     <= IDLE;
                            r_beat      <= '0;
                            r_sym_valid <= 1'b0;
                            r_last      <= 1'b0;
                            r_busy      <= 1'b0;
                            r_frames    <= r_frames + CNT_W'(1);
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                            // Raise last when moving onto the final pad beat.
                            r_last <= (r_beat == BEAT_W'(PAD_BEATS - 2));
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // The shifter is zero-filled, so its top symbol is already 000 during
    // PAD and after the frame drains.
    assign bus.sym_out   = w_word[MSG_W-1 -: SYM_W];
    assign bus.sym_valid = r_sym_valid;
    assign bus.sym_first = r_first;
    assign bus.sym_last  = r_last;
    assign busy          = r_busy;
    assign frames_done   = r_frames;
endmodule

// File: tb/tb_crc3_frame_feeder.sv
module tb_crc3_frame_feeder;
    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_w = 1'b0;
    logic rst_p = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    crc3_frame_feeder_if #(.MSG_W(9))  bif ();
    crc3_frame_feeder_if #(.MSG_W(9))  wif ();
    crc3_frame_feeder_if #(.MSG_W(12)) pif ();

    logic       busy_a, busy_w, busy_p;
    logic [7:0] fd_a;
    logic [1:0] fd_w;
    logic [7:0] fd_p;

    crc3_frame_feeder #(.MSG_W(9), .CRC_W(3), .CNT_W(8)) dut (
        .clk(clk), .reset(rst_a), .bus(bif), .busy(busy_a), .frames_done(fd_a));
    crc3_frame_feeder #(.MSG_W(9), .CRC_W(3), .CNT_W(2)) dut_w (
        .clk(clk), .reset(rst_w), .bus(wif), .busy(busy_w), .frames_done(fd_w));
    crc3_frame_feeder #(.MSG_W(12), .CRC_W(6), .CNT_W(8)) dut_p (
        .clk(clk), .reset(rst_p), .bus(pif), .busy(busy_p), .frames_done(fd_p));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Symbol-channel check on the default instance.
    task automatic chk_sym(input string tag, input logic [2:0] s, input logic f, input logic l);
        chk({tag, ".sym"},   32'(bif.sym_out),   32'(s));
        chk({tag, ".vld"},   32'(bif.sym_valid), 32'd1);
        chk({tag, ".first"}, 32'(bif.sym_first), 32'(f));
        chk({tag, ".last"},  32'(bif.sym_last),  32'(l));
        chk({tag, ".mrdy"},  32'(bif.msg_ready), 32'd0);
    endtask

    logic [1:0] wrap_exp [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0] p_exp    [6] = '{3'b101, 3'b010, 3'b111, 3'b100, 3'b000, 3'b000};

    initial begin
        bif.msg_in = '0; bif.msg_valid = 1'b0; bif.sym_ready = 1'b1;
        wif.msg_in = '0; wif.msg_valid = 1'b0; wif.sym_ready = 1'b1;
        pif.msg_in = '0; pif.msg_valid = 1'b0; pif.sym_ready = 1'b1;
        tick();
        tick();
        // Reset state
        chk("rst.sym",   32'(bif.sym_out),   32'd0);
        chk("rst.vld",   32'(bif.sym_valid), 32'd0);
        chk("rst.first", 32'(bif.sym_first), 32'd0);
        chk("rst.last",  32'(bif.sym_last),  32'd0);
        chk("rst.busy",  32'(busy_a),        32'd0);
        chk("rst.fd",    32'(fd_a),          32'd0);
        rst_a = 1'b1; rst_w = 1'b1; rst_p = 1'b1;
        #1;
        chk("rst.mrdy",  32'(bif.msg_ready), 32'd1);

        // Test 1: basic frame; test 3 request held throughout it
        bif.msg_in = 9'b101011010; bif.msg_valid = 1'b1;
        tick();
        bif.msg_in = 9'b111000111;
        chk_sym("t1.b1", 3'b101, 1'b1, 1'b0);
        chk("t1.busy", 32'(busy_a), 32'd1);
        tick(); chk_sym("t1.b2", 3'b011, 1'b0, 1'b0);
        tick(); chk_sym("t1.b3", 3'b010, 1'b0, 1'b0);
        tick(); chk_sym("t1.b4", 3'b000, 1'b0, 1'b1);
        chk("t1.fd_mid", 32'(fd_a), 32'd0);
        tick();
        chk("t1.idle_vld",  32'(bif.sym_valid), 32'd0);
        chk("t1.idle_mrdy", 32'(bif.msg_ready), 32'd1);
        chk("t1.fd",        32'(fd_a),          32'd1);
        chk("t1.busy_end",  32'(busy_a),        32'd0);
        // Test 3: the held request is accepted at this IDLE cycle
        tick(); chk_sym("t3.b1", 3'b111, 1'b1, 1'b0);
        tick(); chk_sym("t3.b2", 3'b000, 1'b0, 1'b0);
        tick(); chk_sym("t3.b3", 3'b111, 1'b0, 1'b0);
        tick(); chk_sym("t3.b4", 3'b000, 1'b0, 1'b1);
        tick();
        bif.msg_valid = 1'b0;
        chk("t3.fd",  32'(fd_a),          32'd2);
        chk("t3.vld", 32'(bif.sym_valid), 32'd0);

        // Test 2: backpressure on beat 2
        bif.msg_in = 9'b101011010; bif.msg_valid = 1'b1;
        tick();
        bif.msg_valid = 1'b0;
        chk_sym("t2.b1", 3'b101, 1'b1, 1'b0);
        tick();
        chk_sym("t2.b2", 3'b011, 1'b0, 1'b0);
        bif.sym_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_sym($sformatf("t2.stall%0d", i), 3'b011, 1'b0, 1'b0);
        end
        bif.sym_ready = 1'b1;
        tick(); chk_sym("t2.b3", 3'b010, 1'b0, 1'b0);
        tick(); chk_sym("t2.b4", 3'b000, 1'b0, 1'b1);
        tick();
        chk("t2.fd", 32'(fd_a), 32'd3);

        // Test 4: reset mid-frame
        bif.msg_in = 9'b101011010; bif.msg_valid = 1'b1;
        tick();
        bif.msg_valid = 1'b0;
        tick();
        chk_sym("t4.b2", 3'b011, 1'b0, 1'b0);
        rst_a = 1'b0;
        #1;
        chk("t4.sym",   32'(bif.sym_out),   32'd0);
        chk("t4.vld",   32'(bif.sym_valid), 32'd0);
        chk("t4.first", 32'(bif.sym_first), 32'd0);
        chk("t4.last",  32'(bif.sym_last),  32'd0);
        chk("t4.busy",  32'(busy_a),        32'd0);
        chk("t4.fd",    32'(fd_a),          32'd0);
        chk("t4.mrdy",  32'(bif.msg_ready), 32'd0);
        tick();
        tick();
        rst_a = 1'b1;
        #1;
        chk("t4.mrdy_rel", 32'(bif.msg_ready), 32'd1);
        bif.msg_in = 9'b000000001; bif.msg_valid = 1'b1;
        tick();
        bif.msg_valid = 1'b0;
        chk_sym("t4.n1", 3'b000, 1'b1, 1'b0);
        tick(); chk_sym("t4.n2", 3'b000, 1'b0, 1'b0);
        tick(); chk_sym("t4.n3", 3'b001, 1'b0, 1'b0);
        tick(); chk_sym("t4.n4", 3'b000, 1'b0, 1'b1);
        tick();
        chk("t4.fd_new", 32'(fd_a), 32'd1);

        // Test 5: 2-bit frame counter wraps
        for (int f = 0; f < 4; f++) begin
            wif.msg_in = 9'(f * 37); wif.msg_valid = 1'b1;
            tick();
            wif.msg_valid = 1'b0;
            for (int b = 0; b < 4; b++) tick();
            chk($sformatf("t5.fd%0d", f), 32'(fd_w), 32'(wrap_exp[f]));
        end

        // Test 6: MSG_W=12, CRC_W=6
        pif.msg_in = 12'hABC; pif.msg_valid = 1'b1;
        tick();
        pif.msg_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t6.sym%0d", i),   32'(pif.sym_out),   32'(p_exp[i]));
            chk($sformatf("t6.vld%0d", i),   32'(pif.sym_valid), 32'd1);
            chk($sformatf("t6.first%0d", i), 32'(pif.sym_first), 32'(i == 0));
            chk($sformatf("t6.last%0d", i),  32'(pif.sym_last),  32'(i == 5));
            tick();
        end
        chk("t6.vld_end", 32'(pif.sym_valid), 32'd0);
        chk("t6.fd",      32'(fd_p),          32'd1);
        chk("t6.mrdy",    32'(pif.msg_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/crc3_frame_feeder.md
Name: crc3_frame_feeder

Overview:
- Upstream stage of the 3-parallel retimed CRC core.
- Accepts one whole message word through a valid/ready handshake.
- Slices the word MSB-first into 3-bit parallel symbols, one per beat, then appends CRC_W zero bits (augmentation) as further 3-bit beats.
- Frames each message with first/last strobes so the core knows when to clear and when its remainder is final.

Parameters:
- MSG_W, 9, message width in bits; must be a multiple of 3.
- CRC_W, 3, generator degree (zero-pad bits appended); must be a multiple of 3 and at least 3.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- msg_in  in  MSG_W  message word; sampled on accept.
- msg_valid  in  1  upstream has a message.
- msg_ready  out  1  feeder can accept a message.
- sym_out  out  3  parallel symbol to CRC core; bit 2 is the earliest bit.
- sym_valid  out  1  sym_out is valid.
- sym_ready  in  1  CRC core takes the symbol this cycle.
- sym_first  out  1  first data beat of a frame.
- sym_last  out  1  final pad beat of a frame.
- busy  out  1  frame in progress (state != IDLE).
- frames_done  out  CNT_W  count of completed frames; wraps.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, shift register=0, beat counter=0, frames_done=0.
  - sym_out=0, sym_valid=0, sym_first=0, sym_last=0, busy=0.
  - msg_ready=1 once reset deasserts.
- Reset mid-frame drops the frame immediately: no sym_last, no frames_done increment.
- States IDLE, DATA, PAD. All outputs are registered except msg_ready, which is a decode of state==IDLE.
- IDLE:
  - Accept = msg_valid & msg_ready at a rising edge.
  - On accept: load msg_in into the shift register, go to DATA, beat=0.
  - Next cycle: sym_valid=1, sym_first=1, sym_out=msg_in[MSG_W-1:MSG_W-3].
  - Latency from accept edge to first symbol visible: 1 cycle.
- Beat advance: only when sym_valid & sym_ready. While sym_ready=0, sym_out, sym_first and sym_last hold stable.
- DATA:
  - Each advance shifts left 3 and presents the next 3 MSBs; sym_first=0 after the first advance.
  - After MSG_W/3 beats are accepted, go to PAD.
- PAD:
  - sym_out=3'b000 for CRC_W/3 beats.
  - sym_last=1 on the final pad beat only.
  - When the final pad beat is accepted: state goes to IDLE, sym_valid=0, frames_done+1 (wraps 2^CNT_W-1 to 0).
- Frame length: exactly MSG_W/3 + CRC_W/3 accepted beats. Default is 4 beats, 3 data + 1 pad.
- No back-to-back overlap: msg_ready=0 throughout DATA and PAD. The earliest next accept is the cycle after the return to IDLE. msg_valid during busy is ignored, with no loss: upstream must hold it.
- Simultaneous events:
  - In the cycle the last pad beat is accepted, msg_ready is still 0.
  - If sym_ready=0 on the last beat, the frame stays in PAD until accepted.
- With sym_ready tied 1 (core has no backpressure), a default frame takes 4 cycles plus 1 IDLE cycle.

Decomposition:
- Shared package crc_pkg holds:
  - SYM_W=3 (parallelism).
  - State encoding IDLE=2'd0, DATA=2'd1, PAD=2'd2.
  - Derived constants DATA_BEATS=MSG_W/SYM_W and PAD_BEATS=CRC_W/SYM_W.
  - Elaboration checks that MSG_W and CRC_W are multiples of SYM_W.
- One natural sub-module, crc_sym_shifter: MSG_W-bit load/shift-by-3 register with hold enable.
- The FSM, beat counter and frame counter stay in the top.

Test Plan:
1. Basic frame, sym_ready=1: reset low 2 cycles, then msg_in=9'b101011010 with msg_valid=1 for one accept.
   - sym_out must be 101, 011, 010, 000 on 4 consecutive cycles.
   - sym_first only on beat 1, sym_last only on beat 4.
   - frames_done goes 0 to 1; msg_ready=0 for those 4 cycles.
2. Backpressure: same message, sym_ready=0 for 3 cycles during beat 2 (011).
   - sym_out holds 011 with sym_valid=1 throughout the stall.
   - Frame completes 3 cycles late with identical symbol order.
3. Busy-time request: msg_valid held with msg_in=9'b111000111 during the frame from test 1.
   - Not accepted until IDLE.
   - Then yields 111, 000, 111, 000; frames_done=2.
4. Reset mid-frame: assert reset during the beat carrying 011.
   - All outputs 0 asynchronously; frames_done=0; no sym_last.
   - After release, a new frame 9'b000000001 gives 000, 000, 001, 000.
5. Counter wrap (CNT_W=2): run 4 frames; frames_done must read 1, 2, 3, 0.
6. Parameter variant MSG_W=12, CRC_W=6: msg 12'hABC must give 101, 010, 111, 100, 000, 000, with sym_last on the 6th beat.
